pulse_to_level: RTL and testbench
=================================

Name: pulse_to_level

Overview:
- Converts single-cycle pulses into a clean, timed level. It is the receiving end of the level-to-pulse edge detectors used on the clock module's buttons and tick lines.
- Each accepted pulse on P drives L high for a programmable number of cycles. Used for LED/buzzer hold, alarm indication and display blanking.
- Supports retriggering, a post-hold lockout gap, and busy/done status for the controlling FSM.

Parameters:
- HOLD_CYCLES, 4, number of cycles L stays high per accepted pulse; legal range >= 1.
- GAP_CYCLES, 0, lockout cycles after L falls during which P is ignored; 0 means no lockout.
- RETRIGGER, 1, 1 = a pulse during HOLD reloads the hold counter; 0 = pulses during HOLD are ignored.
- CNT_W, clog2(max(HOLD_CYCLES,GAP_CYCLES)+1), counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en   in  1  enable; 0 aborts and holds the block idle.
- P    in  1  pulse input, sampled every cycle (no internal edge detection).
- L    out 1  stretched level output, registered.
- busy out 1  high while in HOLD or GAP, registered.
- done out 1  one-cycle pulse in the first cycle L is low after a completed hold.
- remain out CNT_W  remaining cycles in the current HOLD or GAP; 0 in IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, L=0, busy=0, done=0, remain=0. Release is synchronous to the next clk edge.
- States and transitions (all three are mutually exclusive):
  - IDLE: if en=1 and P=1 -> HOLD, remain=HOLD_CYCLES, L=1, busy=1. Otherwise stay.
  - HOLD, retrigger (P=1 and RETRIGGER=1): remain reloads to HOLD_CYCLES, L stays 1. This also applies when remain==1, and no done is issued.
  - HOLD, remain>1 with no retrigger: remain decrements.
  - HOLD, remain==1 with no retrigger: L=0, done=1 for one cycle. Then -> GAP with remain=GAP_CYCLES if GAP_CYCLES>0; else -> IDLE with remain=0 and busy=0.
  - GAP: P ignored, remain decrements; at remain==1 -> IDLE, remain=0, busy=0.
- Latency: P high in cycle n gives L high in cycles n+1 .. n+HOLD_CYCLES exactly, when there is no retrigger.
- Minimum L-low time between holds is 1+GAP_CYCLES cycles. A pulse on the first IDLE cycle is accepted.
- P held continuously high:
  - RETRIGGER=1: L stays high until HOLD_CYCLES cycles after P falls.
  - RETRIGGER=0: L repeats with period HOLD_CYCLES+1+GAP_CYCLES.
- en=0 in any state: next edge -> IDLE, L=0, busy=0, remain=0, and done is NOT asserted. P is ignored while en=0. en=0 takes priority over P in the same cycle.
- HOLD_CYCLES=1: L is a one-cycle delayed copy of an accepted pulse; done follows in the next cycle.
- Counter never wraps: it is loaded only with a parameter value and decremented only while >=1.
- Output relations: L==1 iff state==HOLD; busy==1 iff state is HOLD or GAP; done is never high together with L.

Decomposition:
- Shared package clk_pkg:
  - state enum p2l_state_t {P2L_IDLE, P2L_HOLD, P2L_GAP}.
  - clog2 helper function.
- One sub-module, p2l_load_counter: loadable down-counter with ports clk, rst, load, load_val, dec, and outputs cnt and is_one.
- The FSM stays in pulse_to_level.

Test Plan:
- Reset mid-hold: rst=0 asynchronously while L=1 -> L, busy, done, remain all 0 immediately; no done after release.
- Basic hold (HOLD=4, GAP=0, RETRIGGER=1): P=1 at cycle 10 -> L=1 cycles 11-14, remain 4,3,2,1, done=1 at cycle 15, busy=0 at 15.
- Retrigger (HOLD=4, RETRIGGER=1): pulses at cycles 10 and 13 -> L=1 cycles 11-17, single done at 18. Edge case: pulse exactly when remain==1 also extends with no done.
- No retrigger with lockout (HOLD=4, GAP=2, RETRIGGER=0):
  - Pulses at 10 and 12: the pulse at 12 is ignored, L=1 cycles 11-14, done at 15.
  - Pulse at 16 (GAP) is ignored; pulse at 17 (IDLE) gives L=1 cycles 18-21.
- Enable abort: P=1 at 10, en=0 at 12 -> L=0 from 13, done never asserted; P=1 with en=0 at 14 -> no response.
- Continuous P (HOLD=3, RETRIGGER=0, GAP=0): P=1 from cycle 10 -> L high 11-13, low 14, high 15-17, with a done pulse at 14 and 18.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared types and helpers for the clock module's pulse/level conditioning blocks.
package clk_pkg;

    typedef enum logic [1:0] {
        P2L_IDLE = 2'd0,
        P2L_HOLD = 2'd1,
        P2L_GAP  = 2'd2
    } p2l_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int p2l_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/p2l_load_counter.sv
// Loadable down-counter that saturates at zero; load takes priority over decrement.
module p2l_load_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             is_one
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/pulse_to_level.sv
// Stretches single-cycle pulses on P into a timed level on L, with optional
// retrigger, post-hold lockout gap and busy/done status.
module pulse_to_level
    import clk_pkg::*;
#(
    parameter  int HOLD_CYCLES = 4,
    parameter  int GAP_CYCLES  = 0,
    parameter  int RETRIGGER   = 1,
    localparam int CNT_W = p2l_clog2(((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             P,
    output logic             L,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remain
);

    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_VAL  = CNT_W'(GAP_CYCLES);

    p2l_state_t       state;
    p2l_state_t       state_nxt;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_is_one;
    logic             l_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    p2l_load_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(cnt_load_val),
        .dec     (cnt_dec),
        .cnt     (remain),
        .is_one  (cnt_is_one)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= P2L_IDLE;
            L     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            L     <= l_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // The counter is reloaded on every state change so remain always reads 0 in IDLE.
    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        if (!en) begin
            state_nxt = P2L_IDLE;
            cnt_load  = 1'b1;
        end else begin
            case (state)
                P2L_IDLE: begin
                    if (P) begin
                        state_nxt    = P2L_HOLD;
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_VAL;
                    end
                end
                P2L_HOLD: begin
                    if (P && (RETRIGGER != 0)) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_VAL;
                    end else if (cnt_is_one) begin
                        cnt_load = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_nxt    = P2L_GAP;
                            cnt_load_val = GAP_VAL;
                        end else begin
                            state_nxt = P2L_IDLE;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                P2L_GAP: begin
                    if (cnt_is_one) begin
                        state_nxt = P2L_IDLE;
                        cnt_load  = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_nxt = P2L_IDLE;
                    cnt_load  = 1'b1;
                end
            endcase
        end
    end

    // done marks only a hold that ran out; an en abort leaves HOLD silently.
    always_comb begin
        l_nxt    = (state_nxt == P2L_HOLD);
        busy_nxt = (state_nxt != P2L_IDLE);
        done_nxt = en && (state == P2L_HOLD) && (state_nxt != P2L_HOLD);
    end

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed bench for pulse_to_level using three parameterisations that share inputs.
module tb_pulse_to_level;

    logic       clk;
    logic       rst;
    logic       en;
    logic       P;
    logic       l_a, busy_a, done_a;
    logic       l_b, busy_b, done_b;
    logic       l_c, busy_c, done_c;
    logic [2:0] rem_a;
    logic [2:0] rem_b;
    logic [1:0] rem_c;
    int         checks;
    int         errors;

    pulse_to_level #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .RETRIGGER(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .P(P),
        .L(l_a), .busy(busy_a), .done(done_a), .remain(rem_a)
    );

    pulse_to_level #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .P(P),
        .L(l_b), .busy(busy_b), .done(done_b), .remain(rem_b)
    );

    pulse_to_level #(.HOLD_CYCLES(3), .GAP_CYCLES(0), .RETRIGGER(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .P(P),
        .L(l_c), .busy(busy_c), .done(done_c), .remain(rem_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b1;
        P   = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (l_a !== 1'b0) begin errors++; $display("FAIL reset_L got=%b exp=0", l_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_a); end
        checks++; if (rem_a !== 3'd0) begin errors++; $display("FAIL reset_remain got=%0d exp=0", rem_a); end
        P = 1'b1;
        tick();
        P = 1'b0;
        tick();
        checks++; if (l_a !== 1'b1) begin errors++; $display("FAIL midhold_L got=%b exp=1", l_a); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (l_a !== 1'b0) begin errors++; $display("FAIL async_rst_L got=%b exp=0", l_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL async_rst_busy got=%b exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL async_rst_done got=%b exp=0", done_a); end
        checks++; if (rem_a !== 3'd0) begin errors++; $display("FAIL async_rst_remain got=%0d exp=0", rem_a); end
        #2;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL post_rst_done cyc=%0d got=%b exp=0", i, done_a); end
            checks++; if (l_a !== 1'b0) begin errors++; $display("FAIL post_rst_L cyc=%0d got=%b exp=0", i, l_a); end
        end
    endtask

    task automatic test_basic_hold();
        do_reset();
        P = 1'b1;
        tick();
        P = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (l_a !== 1'b1) begin errors++; $display("FAIL basic_L cyc=%0d got=%b exp=1", 11 + i, l_a); end
            checks++; if (rem_a !== 3'(4 - i)) begin errors++; $display("FAIL basic_remain cyc=%0d got=%0d exp=%0d", 11 + i, rem_a, 4 - i); end
            checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL basic_busy cyc=%0d got=%b exp=1", 11 + i, busy_a); end
            checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL basic_done cyc=%0d got=%b exp=0", 11 + i, done_a); end
            tick();
        end
        checks++; if (l_a !== 1'b0) begin errors++; $display("FAIL basic_end_L got=%b exp=0", l_a); end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL basic_end_done got=%b exp=1", done_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_end_busy got=%b exp=0", busy_a); end
        checks++; if (rem_a !== 3'd0) begin errors++; $display("FAIL basic_end_remain got=%0d exp=0", rem_a); end
        tick();
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", done_a); end
    endtask

    task automatic test_retrigger();
        logic [8:0] pat;
        logic [8:0] exp_l;
        logic [8:0] exp_d;
        logic [9:0] pat2;
        logic [9:0] exp_l2;
        logic [9:0] exp_d2;
        // pulses at cycles 10 and 13; bit i = cycle 10+i for pat, 11+i for expectations
        pat   = 9'b000001001;
        exp_l = 9'b001111111;
        exp_d = 9'b010000000;
        do_reset();
        P = pat[0];
        for (int i = 0; i < 9; i++) begin
            tick();
            P = (i < 8) ? pat[i+1] : 1'b0;
            checks++; if (l_a !== exp_l[i]) begin errors++; $display("FAIL retrig_L cyc=%0d got=%b exp=%b", 11 + i, l_a, exp_l[i]); end
            checks++; if (done_a !== exp_d[i]) begin errors++; $display("FAIL retrig_done cyc=%0d got=%b exp=%b", 11 + i, done_a, exp_d[i]); end
        end
        // second pulse lands exactly on remain==1 (cycle 14)
        pat2   = 10'b0000010001;
        exp_l2 = 10'b0011111111;
        exp_d2 = 10'b0100000000;
        do_reset();
        P = pat2[0];
        for (int i = 0; i < 10; i++) begin
            tick();
            P = (i < 9) ? pat2[i+1] : 1'b0;
            checks++; if (l_a !== exp_l2[i]) begin errors++; $display("FAIL retrig1_L cyc=%0d got=%b exp=%b", 11 + i, l_a, exp_l2[i]); end
            checks++; if (done_a !== exp_d2[i]) begin errors++; $display("FAIL retrig1_done cyc=%0d got=%b exp=%b", 11 + i, done_a, exp_d2[i]); end
            if (i == 4) begin
                checks++; if (rem_a !== 3'd4) begin errors++; $display("FAIL retrig1_reload got=%0d exp=4", rem_a); end
            end
        end
    endtask

    task automatic test_lockout();
        logic [11:0] pat;
        logic [11:0] exp_l;
        logic [11:0] exp_b;
        logic [11:0] exp_d;
        // pulses at 10, 12 (ignored in HOLD), 16 (ignored in GAP), 17 (accepted)
        pat   = 12'b000011000101;
        exp_l = 12'b011110001111;
        exp_b = 12'b111110111111;
        exp_d = 12'b100000010000;
        do_reset();
        P = pat[0];
        for (int i = 0; i < 12; i++) begin
            tick();
            P = (i < 11) ? pat[i+1] : 1'b0;
            checks++; if (l_b !== exp_l[i]) begin errors++; $display("FAIL lockout_L cyc=%0d got=%b exp=%b", 11 + i, l_b, exp_l[i]); end
            checks++; if (busy_b !== exp_b[i]) begin errors++; $display("FAIL lockout_busy cyc=%0d got=%b exp=%b", 11 + i, busy_b, exp_b[i]); end
            checks++; if (done_b !== exp_d[i]) begin errors++; $display("FAIL lockout_done cyc=%0d got=%b exp=%b", 11 + i, done_b, exp_d[i]); end
            if (i == 4) begin
                checks++; if (rem_b !== 3'd2) begin errors++; $display("FAIL lockout_gap_remain got=%0d exp=2", rem_b); end
            end
        end
    endtask

    task automatic test_enable_abort();
        do_reset();
        P = 1'b1;
        tick();
        P = 1'b0;
        checks++; if (l_a !== 1'b1) begin errors++; $display("FAIL abort_L11 got=%b exp=1", l_a); end
        tick();
        checks++; if (l_a !== 1'b1) begin errors++; $display("FAIL abort_L12 got=%b exp=1", l_a); end
        en = 1'b0;
        tick();
        checks++; if (l_a !== 1'b0) begin errors++; $display("FAIL abort_L13 got=%b exp=0", l_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy13 got=%b exp=0", busy_a); end
        checks++; if (rem_a !== 3'd0) begin errors++; $display("FAIL abort_remain13 got=%0d exp=0", rem_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL abort_done13 got=%b exp=0", done_a); end
        tick();
        P = 1'b1;
        tick();
        P = 1'b0;
        checks++; if (l_a !== 1'b0) begin errors++; $display("FAIL abort_p_ignored_L got=%b exp=0", l_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_p_ignored_busy got=%b exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL abort_done15 got=%b exp=0", done_a); end
        tick();
        checks++; if (l_a !== 1'b0) begin errors++; $display("FAIL abort_L16 got=%b exp=0", l_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL abort_done16 got=%b exp=0", done_a); end
        en = 1'b1;
        tick();
        checks++; if (l_a !== 1'b0) begin errors++; $display("FAIL abort_reenable_L got=%b exp=0", l_a); end
    endtask

    task automatic test_continuous();
        logic [7:0] exp_l;
        logic [7:0] exp_d;
        exp_l = 8'b01110111;
        exp_d = 8'b10001000;
        do_reset();
        P = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            P = (i < 7);
            checks++; if (l_c !== exp_l[i]) begin errors++; $display("FAIL cont_L cyc=%0d got=%b exp=%b", 11 + i, l_c, exp_l[i]); end
            checks++; if (done_c !== exp_d[i]) begin errors++; $display("FAIL cont_done cyc=%0d got=%b exp=%b", 11 + i, done_c, exp_d[i]); end
        end
        P = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        en  = 1'b1;
        P   = 1'b0;
        test_reset();
        test_basic_hold();
        test_retrigger();
        test_lockout();
        test_enable_abort();
        test_continuous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
